pipe_if_id_buf: RTL
===================

Name: pipe_if_id_buf

Overview:
- Fetch-to-decode boundary: captures {pc, pc4, instruction} from the IF stage each cycle and presents them to ID.
- Replaces a bare IF/ID register with a small skid FIFO, so an ID stall never has to combinationally back-pressure the PC mux.
- Handles branch/exception flush, and tags misaligned fetch PCs with an address-error exception for the CP0 logic downstream.

Parameters:
- DEPTH, 2, number of buffer entries; power of two, at least 2.
- NOP_WORD, 32'h00000000, instruction value presented when empty, flushed or faulted (sll $0,$0,0).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_pc  input  32  PC of the fetched instruction.
- in_pc4  input  32  pc + 4 from the IF adder.
- in_instr  input  32  word read from imem.
- in_valid  input  1  IF presents a valid fetch this cycle.
- in_ready  output  1  buffer can accept; doubles as the PC-register write enable.
- flush  input  1  redirect (taken branch, jump, jr/jalr, exception); discards all buffered and incoming fetches.
- out_pc  output  32  PC of the head entry.
- out_pc4  output  32  pc4 of the head entry.
- out_instr  output  32  head instruction; NOP_WORD when out_valid=0 or out_exc=1.
- out_valid  output  1  head entry valid.
- out_exc  output  1  head entry carries a fetch address error.
- id_ready  input  1  ID consumes the head this cycle (low = ID stall).
- occupancy  output  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset (asynchronous, immediate): occupancy=0, rd/wr pointers=0, out_valid=0, out_exc=0, out_pc=0, out_pc4=0, out_instr=NOP_WORD; all entry storage cleared.
- in_ready = (occupancy != DEPTH); combinational from registered state only, with no path from id_ready or in_valid.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & id_ready & ~flush.
- Both push and pop take effect on the same rising edge.
- Entry stores {pc, pc4, instr, exc}.
  - exc = (in_pc[1:0] != 2'b00).
  - When exc=1, the stored instr is NOP_WORD.
- Head outputs are driven from storage at rd pointer; out_valid = (occupancy != 0).
- Latency: a push in cycle N appears on the outputs in cycle N+1 at the earliest. There is no combinational bypass.
- Simultaneous push and pop when not full: occupancy unchanged and both pointers advance.
- When full, in_ready=0, so no push occurs even if a pop happens in the same cycle. in_ready rises the cycle after the pop.
- Pointers wrap modulo DEPTH.
- flush has priority over everything. On the next edge:
  - occupancy=0 and pointers reset to 0;
  - the same-cycle input is discarded;
  - no pop is counted.
- flush while empty is a no-op apart from resetting the pointers.
- Reset asserted mid-operation clears state immediately. The first push after reset deassertion is accepted normally.
- id_ready while out_valid=0 is ignored.
- occupancy never exceeds DEPTH and never underflows.

Test Plan:
- Reset then a stream: in_valid=1 with pc=0x00400000,0x00400004,0x00400008 and id_ready=1 -> out_valid rises 1 cycle later; out_pc follows 0x00400000,…; out_pc4 = out_pc+4; occupancy stays 1.
- ID stall: id_ready=0 for 4 cycles while fetching -> occupancy reaches 2, in_ready=0 from the 3rd cycle, head stays pc=0x00400000. Release id_ready -> entries drain in order with no loss or duplication.
- Flush with full buffer plus a valid input: flush=1 for one cycle -> next cycle occupancy=0, out_valid=0, out_instr=0. The next fetch at pc=0xBFC00380 is the first entry seen.
- Misaligned fetch: in_pc=0x00400002, in_instr=0x8C010000 -> out_exc=1, out_instr=0x00000000, out_pc=0x00400002.
- Full plus pop in the same cycle with in_valid=1 -> no push that cycle, occupancy=1 next cycle, in_ready=1.
- Async reset asserted between clock edges with occupancy=2 -> out_valid=0 and occupancy=0 before the next clk edge.

Source files
------------

// File: rtl/pipe_if_id_buf.sv
// IF/ID boundary skid FIFO: buffers {pc, pc4, instr, exc} between fetch and decode.
// in_ready depends only on registered occupancy, so an ID stall never reaches the PC mux combinationally.
module pipe_if_id_buf #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_pc4,
  input  logic [31:0]                in_instr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_pc4,
  output logic [31:0]                out_instr,
  output logic                       out_valid,
  output logic                       out_exc,
  input  logic                       id_ready,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   r_pc    [DEPTH];
  logic [31:0]   r_pc4   [DEPTH];
  logic [31:0]   r_instr [DEPTH];
  logic          r_exc   [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_occ;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_in_exc;

  assign w_full   = (r_occ == FULL_CNT);
  assign w_empty  = (r_occ == '0);
  assign w_push   = in_valid & ~w_full & ~flush;
  assign w_pop    = ~w_empty & id_ready & ~flush;
  assign w_in_exc = (in_pc[1:0] != 2'b00);

  assign in_ready  = ~w_full;
  assign occupancy = r_occ;
  assign out_valid = ~w_empty;
  assign out_pc    = r_pc[r_rd];
  assign out_pc4   = r_pc4[r_rd];
  assign out_exc   = ~w_empty & r_exc[r_rd];
  assign out_instr = (w_empty | r_exc[r_rd]) ? NOP_WORD : r_instr[r_rd];

  // Faulted fetches are stored as NOP so a bad imem word can never reach decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_pc4[i]   <= '0;
        r_instr[i] <= NOP_WORD;
        r_exc[i]   <= 1'b0;
      end
    end else if (w_push) begin
      r_pc[r_wr]    <= in_pc;
      r_pc4[r_wr]   <= in_pc4;
      r_instr[r_wr] <= w_in_exc ? NOP_WORD : in_instr;
      r_exc[r_wr]   <= w_in_exc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_occ <= '0;
    end else if (flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_occ <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + CW'(1);
        2'b01:   r_occ <= r_occ - CW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule
